mul_hilo_unit: RTL

Multi-cycle control and result stage wrapped around the combinational 32×32 signed multiplier `mul_32bit`. Registers the two operands on a start handshake and holds them steady on `mul_32bit` for a fixed number of settle cycles. It then writes the 64-bit product into the HI/LO register pair and pulses `done`. HI/LO also accept direct writes (mthi/mtlo) and drive the datapath bus muxes.

---
 rtl/mul_hilo_pkg.sv | 13 +
 rtl/hilo_regfile.sv | 33 +++
 rtl/mul_32bit.sv | 12 +
 rtl/mul_hilo_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/mul_hilo_pkg.sv
// Shared definitions for the multiply/HI-LO stage: default operand width,
// settle-counter width and the control FSM state encoding.
package mul_hilo_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int CNT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } mul_state_e;

endpackage

// File: rtl/hilo_regfile.sv
// HI/LO register pair. Write priority: clr, then product write, then the
// direct mthi/mtlo writes (which may both fire at once).
module hilo_regfile
    import mul_hilo_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               prod_wr,
    input  logic [2*WIDTH-1:0] prod,
    input  logic               hi_wr,
    input  logic               lo_wr,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    // HI/LO update with clr > product > direct write priority
    always_ff @(posedge clk) begin
        if (clr) begin
            hi <= '0;
            lo <= '0;
        end else if (prod_wr) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
        end else begin
            if (hi_wr) hi <= wr_data;
            if (lo_wr) lo <= wr_data;
        end
    end

endmodule

// File: rtl/mul_32bit.sv
// Combinational 32x32 two's-complement multiplier. Its output is only
// sampled after the operands have been held for the configured settle cycles.
module mul_32bit (
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [63:0] product
);

    // Full-width signed product, operands sign-extended to 64 bits first
    assign product = 64'($signed(multiplicand)) * 64'($signed(multiplier));

endmodule

// File: rtl/mul_hilo_unit.sv
// Multi-cycle control around an external combinational multiplier.
// Handshake: a multiply is accepted on a rising edge where start=1 and
// ready=1; start while busy is ignored (not queued). Operands are held on
// mul_a/mul_b for SETTLE_CYCLES cycles, then the product lands in HI/LO and
// done pulses for one cycle. ready is already high during the done cycle, so
// a new start there is accepted back-to-back.
module mul_hilo_unit
    import mul_hilo_pkg::*;
#(
    parameter int WIDTH         = MUL_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    input  logic               hi_wr,
    input  logic               lo_wr,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [WIDTH-1:0]   hi_out,
    output logic [WIDTH-1:0]   lo_out
);

    // Counter value on the final settle cycle (completion edge)
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

    mul_state_e           state_q;
    mul_state_e           state_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 done_q;
    logic                 accept;
    logic                 complete;

    // State register
    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)    state_d = ST_SETTLE;
            ST_SETTLE: if (complete) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state and counter
    always_comb begin
        ready    = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
        accept   = (state_q == ST_IDLE) && start;
        complete = (state_q == ST_SETTLE) && (cnt == CNT_LAST);
    end

    // Operand capture, settle counter and registered done pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= complete;
            if (accept) begin
                opa <= multiplicand;
                opb <= multiplier;
                cnt <= '0;
            end else if (state_q == ST_SETTLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign mul_a = opa;
    assign mul_b = opb;
    assign done  = done_q;

    hilo_regfile #(
        .WIDTH(WIDTH)
    ) u_hilo (
        .clk    (clk),
        .clr    (clr),
        .prod_wr(complete),
        .prod   (mul_p),
        .hi_wr  (hi_wr),
        .lo_wr  (lo_wr),
        .wr_data(wr_data),
        .hi     (hi_out),
        .lo     (lo_out)
    );

endmodule
